// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants and types for the UART receive path.
//   UART_BYTE_W         : width of one received character
//   RX_DEPTH_LOG2_DEF   : default log2 depth of the receive FIFO
//   RX_HIGH_WM_DEF      : default occupancy at which the host is paused
//   RX_LOW_WM_DEF       : default occupancy at which the host is released
//   rx_fc_state_t       : flow-control state encoding (RX_READY / RX_PAUSE)
//   rx_wm_ok()          : helper, true when a watermark pair is usable
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W       = 8;
  localparam int RX_DEPTH_LOG2_DEF = 4;
  localparam int RX_HIGH_WM_DEF    = 12;
  localparam int RX_LOW_WM_DEF     = 4;

  // READY lets the host transmit; PAUSE asks it to hold off.
  typedef enum logic {
    RX_READY = 1'b0,
    RX_PAUSE = 1'b1
  } rx_fc_state_t;

  // Hysteresis only makes sense when the low mark sits strictly below the
  // high mark and the high mark is reachable.
  function automatic bit rx_wm_ok(input int depth, input int high_wm, input int low_wm);
    return (low_wm < high_wm) && (high_wm <= depth) && (low_wm >= 0);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo_if
// Groups the receive-FIFO handshake signals.
//   in_valid / in_data  : byte strobe from the deserializer
//   rd_en               : pop request from the peripheral bus
//   clr_overflow        : one-cycle pulse clearing the sticky overflow flag
//   rd_data / rd_valid  : head byte (0 when empty) and non-empty flag
//   count               : occupancy 0..DEPTH
//   rx_ready            : flow control to the host, 1 = may send
//   overflow            : sticky byte-dropped flag
// Modports:
//   master : the side producing bytes / reading the bus (deserializer + bus)
//   slave  : the FIFO itself
// ---------------------------------------------------------------------------
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2_DEF
) ();

  logic                   in_valid;
  logic [UART_BYTE_W-1:0] in_data;
  logic                   rd_en;
  logic                   clr_overflow;
  logic [UART_BYTE_W-1:0] rd_data;
  logic                   rd_valid;
  logic [DEPTH_LOG2:0]    count;
  logic                   rx_ready;
  logic                   overflow;

  modport master (
    output in_valid,
    output in_data,
    output rd_en,
    output clr_overflow,
    input  rd_data,
    input  rd_valid,
    input  count,
    input  rx_ready,
    input  overflow
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  rd_en,
    input  clr_overflow,
    output rd_data,
    output rd_valid,
    output count,
    output rx_ready,
    output overflow
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// ---------------------------------------------------------------------------
// uart_fifo_mem
// Parameterised register array: one synchronous write port and one
// asynchronous (combinational) read port. Contents are not reset.
//   cpu_clk : clock, writes on rising edge
//   we      : write enable
//   waddr   : write address
//   wdata   : write data
//   raddr   : read address
//   rdata   : mem[raddr], combinational
// ---------------------------------------------------------------------------
module uart_fifo_mem #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              cpu_clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];

  always_ff @(posedge cpu_clk) begin
    if (we) begin
      mem_reg[waddr] <= wdata;
    end
  end

  // Asynchronous read so the head byte is visible the cycle after it lands.
  assign rdata = mem_reg[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
// Receive-side first-word-fall-through byte FIFO between the UART
// deserializer and the peripheral read mux, with hysteretic flow control
// and a sticky overflow flag.
// Ports:
//   cpu_clk : clock, all state updates on rising edge
//   rstn    : synchronous, active-low reset
//   bus     : uart_rx_fifo_if.slave
//             (in_valid, in_data, rd_en, clr_overflow in;
//              rd_data, rd_valid, count, rx_ready, overflow out)
// Notes:
//   - count is its own register rather than a pointer difference, so full
//     and empty are unambiguous with DEPTH_LOG2-bit wrapping pointers.
//   - rd_valid, count, overflow and rx_ready are registers or direct decodes
//     of registers; rd_data is the array read gated by rd_valid.
// ---------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = RX_DEPTH_LOG2_DEF,
  parameter int HIGH_WM    = RX_HIGH_WM_DEF,
  parameter int LOW_WM     = RX_LOW_WM_DEF
) (
  input logic           cpu_clk,
  input logic           rstn,
  uart_rx_fifo_if.slave bus
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]      HIGH_CNT = CNT_W'(HIGH_WM);
  localparam logic [CNT_W-1:0]      LOW_CNT  = CNT_W'(LOW_WM);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

  // Watermarks that cannot produce hysteresis are a configuration bug.
  localparam bit WM_VALID = rx_wm_ok(DEPTH, HIGH_WM, LOW_WM);

  logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;
  logic [CNT_W-1:0]       count_next;
  logic                   overflow_reg;
  logic                   rx_ready_reg;
  rx_fc_state_t           fc_state_reg;

  logic                   push;
  logic                   pop;
  logic                   drop;
  logic                   mem_we;
  logic [UART_BYTE_W-1:0] head_data;
  logic                   not_empty;

  // -------------------------------------------------------------------------
  // Push / pop qualification
  // A pop only happens when there is something to pop, so an empty FIFO
  // with in_valid+rd_en just takes the push. A full FIFO accepts a push
  // only when the same cycle's pop frees a slot.
  // -------------------------------------------------------------------------
  always_comb begin
    pop        = bus.rd_en && (count_reg != '0);
    push       = bus.in_valid && ((count_reg < FULL_CNT) || pop);
    drop       = bus.in_valid && !push;
    count_next = count_reg;
    if (push && !pop) begin
      count_next = count_reg + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count_reg - CNT_ONE;
    end
  end

  // Keep the array quiet while reset is held; pointers are being cleared
  // anyway, but this keeps a strobe coincident with reset from landing.
  assign mem_we = push && rstn && WM_VALID;

  uart_fifo_mem #(
    .ADDR_W (DEPTH_LOG2),
    .DATA_W (UART_BYTE_W)
  ) u_mem (
    .cpu_clk (cpu_clk),
    .we      (mem_we),
    .waddr   (wr_ptr_reg),
    .wdata   (bus.in_data),
    .raddr   (rd_ptr_reg),
    .rdata   (head_data)
  );

  // -------------------------------------------------------------------------
  // Pointers, occupancy and sticky overflow
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      end
      count_reg <= count_next;
      // A new drop outranks a clear arriving in the same cycle, so firmware
      // never loses the evidence of a drop it has not yet seen.
      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (bus.clr_overflow) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Flow-control FSM, evaluated on next-state occupancy so rx_ready changes
  // on the same edge that moves count across a watermark.
  // -------------------------------------------------------------------------
  always_ff @(posedge cpu_clk) begin
    if (!rstn) begin
      fc_state_reg <= RX_READY;
      rx_ready_reg <= 1'b1;
    end else begin
      case (fc_state_reg)
        RX_READY: begin
          if (count_next >= HIGH_CNT) begin
            fc_state_reg <= RX_PAUSE;
            rx_ready_reg <= 1'b0;
          end
        end
        RX_PAUSE: begin
          if (count_next <= LOW_CNT) begin
            fc_state_reg <= RX_READY;
            rx_ready_reg <= 1'b1;
          end
        end
        default: begin
          fc_state_reg <= RX_READY;
          rx_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign not_empty    = (count_reg != '0);
  assign bus.rd_valid = not_empty;
  assign bus.rd_data  = not_empty ? head_data : '0;
  assign bus.count    = count_reg;
  assign bus.rx_ready = rx_ready_reg;
  assign bus.overflow = overflow_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed bench for uart_rx_fifo. Inputs change 1 ns after each rising
// edge and outputs are sampled at the same point, i.e. after the edge has
// settled. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic cpu_clk;
  logic rstn;

  int n_assert;
  int n_fail;

  uart_rx_fifo_if #(.DEPTH_LOG2(4)) bus ();

  uart_rx_fifo #(
    .DEPTH_LOG2 (4),
    .HIGH_WM    (12),
    .LOW_WM     (4)
  ) dut (
    .cpu_clk (cpu_clk),
    .rstn    (rstn),
    .bus     (bus)
  );

  initial cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
  endtask

  task automatic pop();
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    n_assert          = 0;
    n_fail            = 0;
    rstn              = 1'b0;
    bus.in_valid      = 1'b0;
    bus.in_data       = 8'h00;
    bus.rd_en         = 1'b0;
    bus.clr_overflow  = 1'b0;

    // Reset then idle
    tick();
    tick();
    rstn = 1'b1;
    tick();
    check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
    check("rst_rd_data",  32'(bus.rd_data),  32'h00);
    check("rst_count",    32'(bus.count),    32'd0);
    check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("rst_overflow", 32'(bus.overflow), 32'd0);
    $display("txn reset: count=%0d rx_ready=%0d", bus.count, bus.rx_ready);

    // Single byte round trip
    push(8'hA5);
    check("a5_rd_valid", 32'(bus.rd_valid), 32'd1);
    check("a5_rd_data",  32'(bus.rd_data),  32'hA5);
    check("a5_count",    32'(bus.count),    32'd1);
    $display("txn push 0xa5: rd_data=0x%02h count=%0d", bus.rd_data, bus.count);
    pop();
    check("a5_pop_count", 32'(bus.count),    32'd0);
    check("a5_pop_data",  32'(bus.rd_data),  32'h00);
    check("a5_pop_valid", 32'(bus.rd_valid), 32'd0);
    $display("txn pop: count=%0d", bus.count);

    // rd_en while empty does nothing
    pop();
    check("empty_pop_count",    32'(bus.count),    32'd0);
    check("empty_pop_overflow", 32'(bus.overflow), 32'd0);

    // Empty with in_valid+rd_en: push taken, pop ignored
    bus.rd_en = 1'b1;
    push(8'h77);
    bus.rd_en = 1'b0;
    check("empty_both_count", 32'(bus.count),   32'd1);
    check("empty_both_data",  32'(bus.rd_data), 32'h77);
    $display("txn empty push+pop: count=%0d rd_data=0x%02h", bus.count, bus.rd_data);
    pop();
    check("empty_both_drain", 32'(bus.count), 32'd0);

    // Fill 16, overflow with 0x10, drain in order
    for (int i = 0; i < 16; i++) push(8'(i));
    check("fill_count",    32'(bus.count),    32'd16);
    check("fill_rx_ready", 32'(bus.rx_ready), 32'd0);
    check("fill_overflow", 32'(bus.overflow), 32'd0);
    push(8'h10);
    check("ovf_count",    32'(bus.count),    32'd16);
    check("ovf_flag",     32'(bus.overflow), 32'd1);
    check("ovf_head",     32'(bus.rd_data),  32'h00);
    $display("txn push 0x10 on full: count=%0d overflow=%0d", bus.count, bus.overflow);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_%0d", i), 32'(bus.rd_data), 32'(i));
      $display("txn pop %0d: rd_data=0x%02h", i, bus.rd_data);
      pop();
    end
    check("drain_count",    32'(bus.count),    32'd0);
    check("drain_rx_ready", 32'(bus.rx_ready), 32'd1);
    check("drain_overflow", 32'(bus.overflow), 32'd1);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("clr_overflow", 32'(bus.overflow), 32'd0);

    // Full with simultaneous push+pop
    for (int i = 0; i < 16; i++) push(8'(i));
    bus.rd_en = 1'b1;
    push(8'h55);
    bus.rd_en = 1'b0;
    check("full_both_count",    32'(bus.count),    32'd16);
    check("full_both_head",     32'(bus.rd_data),  32'h01);
    check("full_both_overflow", 32'(bus.overflow), 32'd0);
    $display("txn full push 0x55+pop: count=%0d head=0x%02h", bus.count, bus.rd_data);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fb_drain_%0d", i), 32'(bus.rd_data), (i == 15) ? 32'h55 : 32'(i + 1));
      pop();
    end
    check("fb_drain_count", 32'(bus.count), 32'd0);

    // Flow-control hysteresis
    for (int i = 0; i < 11; i++) push(8'(8'h20 + i));
    check("fc_11_ready", 32'(bus.rx_ready), 32'd1);
    check("fc_11_count", 32'(bus.count),    32'd11);
    push(8'h2B);
    check("fc_12_ready", 32'(bus.rx_ready), 32'd0);
    $display("txn 12th push: rx_ready=%0d", bus.rx_ready);
    for (int i = 0; i < 7; i++) pop();
    check("fc_5_count", 32'(bus.count),    32'd5);
    check("fc_5_ready", 32'(bus.rx_ready), 32'd0);
    check("fc_5_head",  32'(bus.rd_data),  32'h27);
    pop();
    check("fc_4_count", 32'(bus.count),    32'd4);
    check("fc_4_ready", 32'(bus.rx_ready), 32'd1);
    $display("txn pop to 4: rx_ready=%0d", bus.rx_ready);
    for (int i = 0; i < 4; i++) pop();
    check("fc_drain", 32'(bus.count), 32'd0);

    // Overflow set beats clear
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    bus.clr_overflow = 1'b1;
    push(8'hEE);
    bus.clr_overflow = 1'b0;
    check("prec_overflow", 32'(bus.overflow), 32'd1);
    check("prec_count",    32'(bus.count),    32'd16);
    $display("txn overflow+clr: overflow=%0d", bus.overflow);
    bus.clr_overflow = 1'b1;
    tick();
    bus.clr_overflow = 1'b0;
    check("prec_clear", 32'(bus.overflow), 32'd0);
    push(8'hEF);
    check("prec_reset_pre", 32'(bus.overflow), 32'd1);
    do_reset();
    check("full_rst_count",    32'(bus.count),    32'd0);
    check("full_rst_overflow", 32'(bus.overflow), 32'd0);
    check("full_rst_ready",    32'(bus.rx_ready), 32'd1);

    // Reset mid-operation with a coincident strobe
    for (int i = 0; i < 7; i++) push(8'(8'h60 + i));
    check("mid_count", 32'(bus.count),    32'd7);
    check("mid_ready", 32'(bus.rx_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h99;
    rstn         = 1'b0;
    tick();
    rstn         = 1'b1;
    bus.in_valid = 1'b0;
    check("mid_rst_count",    32'(bus.count),    32'd0);
    check("mid_rst_valid",    32'(bus.rd_valid), 32'd0);
    check("mid_rst_overflow", 32'(bus.overflow), 32'd0);
    check("mid_rst_data",     32'(bus.rd_data),  32'h00);
    $display("txn reset mid-op: count=%0d rd_valid=%0d", bus.count, bus.rd_valid);
    push(8'h3C);
    check("post_rst_data",  32'(bus.rd_data), 32'h3C);
    check("post_rst_count", 32'(bus.count),   32'd1);
    $display("txn push 0x3c: rd_data=0x%02h", bus.rd_data);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side byte buffer between the UART deserializer and the CPU peripheral bus read path. It captures each received byte strobe into a first-word-fall-through FIFO and presents the head byte plus status to the peripheral read mux. It drives hysteretic flow control back to the host, and keeps a sticky overflow flag, so bytes are not lost while firmware is busy.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (DEPTH = 16 entries)
HIGH_WM, 12, occupancy at or above which rx_ready drops
LOW_WM, 4, occupancy at or below which rx_ready re-asserts (must be < HIGH_WM)

Ports:
cpu_clk  in  1  system clock; all state updates on its rising edge
rstn  in  1  reset; synchronous, active-low
in_valid  in  1  one-cycle strobe from the deserializer: in_data holds a new byte
in_data  in  8  received byte
rd_en  in  1  pop request from the bus (peripheral read of the RX data register)
rd_data  out  8  head byte (FWFT); 0 when empty
rd_valid  out  1  FIFO non-empty
count  out  DEPTH_LOG2+1  current occupancy, 0..DEPTH
rx_ready  out  1  flow control to host; 1 = may send
overflow  out  1  sticky: a byte was dropped because the FIFO was full
clr_overflow  in  1  one-cycle pulse that clears overflow

Behaviour:
- Reset (rstn=0 at a clock edge): wr_ptr=0, rd_ptr=0, count=0, overflow=0, rx_ready=1. Memory contents are not reset; rd_data is forced to 0 while empty.
- Storage: DEPTH x 8 register array with synchronous write and asynchronous read at rd_ptr.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo DEPTH. count is a separate register, not derived from the pointers.
- push = in_valid && (count<DEPTH || pop). pop = rd_en && count!=0.
  - On push: mem[wr_ptr] <= in_data and wr_ptr++.
  - On pop: rd_ptr++.
  - count <= count + push - pop.
- Latency: a byte pushed at edge N is visible on rd_data/rd_valid after edge N (one cycle from strobe to readable).
- Simultaneous cases:
  - Empty with in_valid+rd_en: the pop is ignored and the push is accepted; count becomes 1.
  - Full with in_valid+rd_en: both are accepted; count stays at DEPTH, and the new byte lands in the slot just freed.
  - Full with in_valid and no rd_en: the byte is dropped, pointers and count are unchanged, and overflow <= 1.
- rd_en while empty: no effect, no error flag.
- overflow priority: a set in the same cycle as clr_overflow wins, so overflow stays 1. Otherwise clr_overflow clears it.
- rx_ready is a registered two-state machine evaluated on next-state count:
  - READY (rx_ready=1) goes to PAUSE when count_next >= HIGH_WM.
  - PAUSE (rx_ready=0) goes to READY when count_next <= LOW_WM.
  - No other transitions.
- Any cycle with rstn=0 aborts everything. The FIFO is empty afterwards; a byte strobed in the same cycle as reset is discarded.
- Outputs rd_valid, count, overflow and rx_ready are registered or direct register decodes. rd_data is a combinational read of the array gated by rd_valid.

Decomposition:
- Shared package (uart_pkg): UART_BYTE_W=8, default depth and watermark constants, and the rx_ready state encoding (RX_READY, RX_PAUSE).
- One sub-module, uart_fifo_mem: a parameterised register array with write port (we, waddr, wdata) and async read port (raddr, rdata).
- Pointer, count, overflow and flow-control logic stay in uart_rx_fifo.

Test Plan:
- Reset then idle: rd_valid=0, rd_data=0, count=0, rx_ready=1, overflow=0. Push 0xA5 → next cycle rd_valid=1, rd_data=0xA5, count=1. Pop → count=0, rd_data=0.
- Push 0x00..0x0F (16 bytes), then 0x10 → count=16, overflow=1, 0x10 is absent. Pop 16 times → reads 0x00..0x0F in order; count=0 at the end.
- Fill to 16, then in_valid=0x55 with rd_en in the same cycle → count stays 16, head advances to 0x01, and the 16th pop returns 0x55. overflow stays 0.
- Flow control: push 11 bytes → rx_ready=1. 12th push → rx_ready=0 after that edge. Pop down to count=5 → still 0. Pop to count=4 → rx_ready=1.
- Overflow precedence: with the FIFO full, assert the overflowing in_valid and clr_overflow together → overflow=1. Next cycle clr_overflow alone → overflow=0.
- Reset mid-operation: with count=7, rx_ready=1 and in_valid asserted, pulse rstn=0 for one cycle → count=0, rd_valid=0, overflow=0. A subsequent push of 0x3C reads back as 0x3C.
